// File: rtl/mpt_memory_stage_if.sv
// Valid/ready/data handshake between walking-pipeline stages.
// The master drives valid and data; the slave drives ready.
interface mpt_memory_stage_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mpt_memory_stage.sv
// Walking-stage memory responder: fetches the MPTE for DO transactions and
// refills the forwarding buffer; SKIP/FWD transactions pass straight through.
//
// state   | meaning
// IDLE    | waiting for a transaction from the forwarding buffer
// REQ     | MPTE read request presented, waiting for mem_req_ready_i
// WAIT    | request accepted, waiting for response / error / timeout
// OUT     | resolved transaction presented to the check stage
//
// Transaction layout: [TDW-1:TDW-2] walking, [TDW-3] valid,
// [TDW-4:16] mpte_ptr, [15:0] mpte (low bits of the fetched entry).
module mpt_memory_stage #(
  parameter int unsigned TRANSACTION_DATA_WIDTH = 32,
  parameter int unsigned MEM_ADDR_WIDTH         = 64,
  parameter int unsigned MPTE_WIDTH             = 64,
  parameter int unsigned MEM_TIMEOUT_CYCLES     = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  mpt_memory_stage_if.slave                 fwd_slave_stage,
  mpt_memory_stage_if.master                chk_master_stage,
  output logic                              fwd_update_valid,
  output logic [TRANSACTION_DATA_WIDTH-1:0] fwd_update_data,
  output logic                              mem_req_valid_o,
  input  logic                              mem_req_ready_i,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_req_addr_o,
  input  logic                              mem_rsp_valid_i,
  input  logic [MPTE_WIDTH-1:0]             mem_rsp_data_i,
  input  logic                              mem_rsp_err_i,
  output logic                              mem_fault_o
);

  localparam int unsigned TDW     = TRANSACTION_DATA_WIDTH;
  localparam int unsigned MF      = 16;
  localparam int unsigned WALK_HI = TDW - 1;
  localparam int unsigned WALK_LO = TDW - 2;
  localparam int unsigned VLD_BIT = TDW - 3;
  localparam int unsigned PTR_HI  = TDW - 4;
  localparam int unsigned PTR_LO  = MF;
  localparam int unsigned CNT_W   = (MEM_TIMEOUT_CYCLES > 1) ? $clog2(MEM_TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] WALK_DO = 2'b01;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_OUT} state_t;

  state_t           state;
  logic [TDW-1:0]   hold;
  logic [CNT_W-1:0] cnt;
  logic             out_valid;
  logic             accept;
  logic             in_is_do;
  logic             unused_rsp_hi;

  // Only the low MF bits of an entry fit in the transaction's mpte field.
  assign unused_rsp_hi = ^mem_rsp_data_i[MPTE_WIDTH-1:MF];

  assign fwd_slave_stage.ready = (state == ST_IDLE) &&
                                 (!out_valid || chk_master_stage.ready);
  assign accept   = fwd_slave_stage.valid && fwd_slave_stage.ready;
  assign in_is_do = fwd_slave_stage.data[VLD_BIT] &&
                    (fwd_slave_stage.data[WALK_HI:WALK_LO] == WALK_DO);

  assign chk_master_stage.valid = out_valid;
  assign chk_master_stage.data  = hold;
  assign fwd_update_data        = hold;
  assign mem_req_addr_o         = MEM_ADDR_WIDTH'(hold[PTR_HI:PTR_LO]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      hold             <= '0;
      cnt              <= '0;
      out_valid        <= 1'b0;
      mem_req_valid_o  <= 1'b0;
      fwd_update_valid <= 1'b0;
      mem_fault_o      <= 1'b0;
    end else begin
      fwd_update_valid <= 1'b0;
      mem_fault_o      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            hold <= fwd_slave_stage.data;
            if (in_is_do) begin
              state           <= ST_REQ;
              mem_req_valid_o <= 1'b1;
            end else begin
              state     <= ST_OUT;
              out_valid <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            cnt             <= '0;
            state           <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid_i) begin
            state     <= ST_OUT;
            out_valid <= 1'b1;
            if (mem_rsp_err_i) begin
              hold[MF-1:0] <= '0;
              mem_fault_o  <= 1'b1;
            end else begin
              hold[MF-1:0]     <= mem_rsp_data_i[MF-1:0];
              fwd_update_valid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            // Zeroed mpte is an invalid entry, so the check stage faults it.
            hold[MF-1:0] <= '0;
            mem_fault_o  <= 1'b1;
            state        <= ST_OUT;
            out_valid    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_OUT: begin
          if (chk_master_stage.ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpt_memory_stage.sv
// Directed bench for mpt_memory_stage: pass-through, refill, error,
// timeout, backpressure and reset during an outstanding read.
module tb_mpt_memory_stage;
  localparam logic [1:0] W_SKIP = 2'b00;
  localparam logic [1:0] W_DO   = 2'b01;
  localparam logic [1:0] W_FWD  = 2'b10;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        fwd_update_valid;
  logic [31:0] fwd_update_data;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [63:0] mem_req_addr_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [63:0] mem_rsp_data_i = '0;
  logic        mem_rsp_err_i = 1'b0;
  logic        mem_fault_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  mpt_memory_stage_if #(.DATA_WIDTH(32)) fwd_if ();
  mpt_memory_stage_if #(.DATA_WIDTH(32)) chk_if ();

  mpt_memory_stage #(.MEM_TIMEOUT_CYCLES(8)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .fwd_slave_stage  (fwd_if),
    .chk_master_stage (chk_if),
    .fwd_update_valid (fwd_update_valid),
    .fwd_update_data  (fwd_update_data),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_rsp_valid_i  (mem_rsp_valid_i),
    .mem_rsp_data_i   (mem_rsp_data_i),
    .mem_rsp_err_i    (mem_rsp_err_i),
    .mem_fault_o      (mem_fault_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mk(input logic [1:0] walk, input logic vld,
                                     input logic [12:0] ptr, input logic [15:0] mpte);
    return {walk, vld, ptr, mpte};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [31:0] txn);
    fwd_if.valid = 1'b1;
    fwd_if.data  = txn;
    step();
    fwd_if.valid = 1'b0;
  endtask

  task automatic test_reset();
    fwd_if.valid = 1'b0;
    fwd_if.data  = '0;
    chk_if.ready = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    total_cnt++;
    if ({chk_if.valid, mem_req_valid_o, fwd_update_valid, mem_fault_o} !== 4'b0000)
      $display("FAIL reset_outputs: got %b expected 0000",
               {chk_if.valid, mem_req_valid_o, fwd_update_valid, mem_fault_o});
    else pass_cnt++;
    step();
    rst_i = 1'b0;
    step();
    total_cnt++;
    if (fwd_if.ready !== 1'b1)
      $display("FAIL reset_ready: got %b expected 1", fwd_if.ready);
    else pass_cnt++;
  endtask

  task automatic test_skip();
    logic [31:0] t;
    t = mk(W_SKIP, 1'b1, 13'h40, 16'h1234);
    chk_if.ready = 1'b1;
    offer(t);
    total_cnt++;
    if (chk_if.valid !== 1'b1 || chk_if.data !== t)
      $display("FAIL skip_out: got v=%b d=%h expected v=1 d=%h", chk_if.valid, chk_if.data, t);
    else pass_cnt++;
    total_cnt++;
    if (mem_req_valid_o !== 1'b0 || fwd_update_valid !== 1'b0)
      $display("FAIL skip_no_mem: got req=%b upd=%b expected 0 0", mem_req_valid_o, fwd_update_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (chk_if.valid !== 1'b0)
      $display("FAIL skip_drain: got %b expected 0", chk_if.valid);
    else pass_cnt++;
  endtask

  task automatic test_passthrough();
    logic [31:0] t [2];
    t[0] = mk(W_FWD, 1'b1, 13'h44, 16'h0abc);
    t[1] = mk(W_DO,  1'b0, 13'h48, 16'h0def);
    for (int i = 0; i < 2; i++) begin
      offer(t[i]);
      total_cnt++;
      if (chk_if.valid !== 1'b1 || chk_if.data !== t[i] || mem_req_valid_o !== 1'b0)
        $display("FAIL passthrough_%0d: got v=%b d=%h req=%b expected v=1 d=%h req=0",
                 i, chk_if.valid, chk_if.data, mem_req_valid_o, t[i]);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_do_wait_states();
    logic [31:0] exp_t;
    exp_t = mk(W_DO, 1'b1, 13'h100, 16'hABCD);
    chk_if.ready    = 1'b1;
    mem_req_ready_i = 1'b0;
    offer(mk(W_DO, 1'b1, 13'h100, 16'h0000));
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 64'h100)
        $display("FAIL do_req_hold_%0d: got v=%b a=%h expected v=1 a=100",
                 i, mem_req_valid_o, mem_req_addr_o);
      else pass_cnt++;
      if (i == 3) mem_req_ready_i = 1'b1;
      step();
    end
    mem_req_ready_i = 1'b0;
    total_cnt++;
    if (mem_req_valid_o !== 1'b0 || chk_if.valid !== 1'b0)
      $display("FAIL do_wait: got req=%b chk=%b expected 0 0", mem_req_valid_o, chk_if.valid);
    else pass_cnt++;
    step();
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 64'h0000_0000_0000_ABCD;
    step();
    mem_rsp_valid_i = 1'b0;
    total_cnt++;
    if (fwd_update_valid !== 1'b1 || fwd_update_data !== exp_t)
      $display("FAIL do_update: got v=%b d=%h expected v=1 d=%h", fwd_update_valid, fwd_update_data, exp_t);
    else pass_cnt++;
    total_cnt++;
    if (chk_if.valid !== 1'b1 || chk_if.data !== exp_t || mem_fault_o !== 1'b0)
      $display("FAIL do_out: got v=%b d=%h f=%b expected v=1 d=%h f=0",
               chk_if.valid, chk_if.data, mem_fault_o, exp_t);
    else pass_cnt++;
    step();
    total_cnt++;
    if (fwd_update_valid !== 1'b0 || chk_if.valid !== 1'b0)
      $display("FAIL do_pulse_end: got upd=%b chk=%b expected 0 0", fwd_update_valid, chk_if.valid);
    else pass_cnt++;
  endtask

  task automatic test_do_error();
    logic [31:0] exp_t;
    exp_t = mk(W_DO, 1'b1, 13'h80, 16'h0000);
    chk_if.ready    = 1'b1;
    mem_req_ready_i = 1'b1;
    offer(mk(W_DO, 1'b1, 13'h80, 16'h5555));
    step();
    mem_rsp_valid_i = 1'b1;
    mem_rsp_err_i   = 1'b1;
    mem_rsp_data_i  = 64'hFFFF;
    step();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i   = 1'b0;
    total_cnt++;
    if (chk_if.valid !== 1'b1 || chk_if.data !== exp_t)
      $display("FAIL err_out: got v=%b d=%h expected v=1 d=%h", chk_if.valid, chk_if.data, exp_t);
    else pass_cnt++;
    total_cnt++;
    if (mem_fault_o !== 1'b1 || fwd_update_valid !== 1'b0)
      $display("FAIL err_fault: got f=%b upd=%b expected f=1 upd=0", mem_fault_o, fwd_update_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (mem_fault_o !== 1'b0)
      $display("FAIL err_pulse_end: got %b expected 0", mem_fault_o);
    else pass_cnt++;
    mem_req_ready_i = 1'b0;
  endtask

  task automatic test_timeout();
    logic early;
    logic [31:0] exp_t;
    exp_t = mk(W_DO, 1'b1, 13'h200, 16'h0000);
    early = 1'b0;
    chk_if.ready    = 1'b0;
    mem_req_ready_i = 1'b1;
    offer(mk(W_DO, 1'b1, 13'h200, 16'h9999));
    step();
    mem_req_ready_i = 1'b0;
    for (int w = 0; w < 8; w++) begin
      if (chk_if.valid !== 1'b0 || mem_fault_o !== 1'b0) early = 1'b1;
      step();
    end
    total_cnt++;
    if (early !== 1'b0)
      $display("FAIL timeout_early: got early=%b expected 0", early);
    else pass_cnt++;
    total_cnt++;
    if (mem_fault_o !== 1'b1 || chk_if.valid !== 1'b1 || chk_if.data !== exp_t)
      $display("FAIL timeout_fault: got f=%b v=%b d=%h expected f=1 v=1 d=%h",
               mem_fault_o, chk_if.valid, chk_if.data, exp_t);
    else pass_cnt++;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 64'hBEEF;
    step();
    mem_rsp_valid_i = 1'b0;
    total_cnt++;
    if (fwd_update_valid !== 1'b0 || chk_if.data !== exp_t || mem_fault_o !== 1'b0)
      $display("FAIL timeout_late_rsp: got upd=%b d=%h f=%b expected upd=0 d=%h f=0",
               fwd_update_valid, chk_if.data, mem_fault_o, exp_t);
    else pass_cnt++;
    chk_if.ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_t;
    logic [31:0] nxt;
    exp_t = mk(W_DO, 1'b1, 13'h300, 16'h7777);
    nxt   = mk(W_FWD, 1'b1, 13'h55, 16'h4242);
    chk_if.ready    = 1'b0;
    mem_req_ready_i = 1'b1;
    offer(mk(W_DO, 1'b1, 13'h300, 16'h0000));
    step();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 64'h1234_5678_9ABC_7777;
    step();
    mem_rsp_valid_i = 1'b0;
    fwd_if.valid = 1'b1;
    fwd_if.data  = nxt;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (chk_if.valid !== 1'b1 || chk_if.data !== exp_t || fwd_if.ready !== 1'b0 || mem_req_valid_o !== 1'b0)
        $display("FAIL bp_hold_%0d: got v=%b d=%h rdy=%b req=%b expected v=1 d=%h rdy=0 req=0",
                 i, chk_if.valid, chk_if.data, fwd_if.ready, mem_req_valid_o, exp_t);
      else pass_cnt++;
      step();
    end
    chk_if.ready = 1'b1;
    step();
    total_cnt++;
    if (chk_if.valid !== 1'b0 || fwd_if.ready !== 1'b1)
      $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", chk_if.valid, fwd_if.ready);
    else pass_cnt++;
    step();
    fwd_if.valid = 1'b0;
    total_cnt++;
    if (chk_if.valid !== 1'b1 || chk_if.data !== nxt)
      $display("FAIL bp_next: got v=%b d=%h expected v=1 d=%h", chk_if.valid, chk_if.data, nxt);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] exp_t;
    exp_t = mk(W_DO, 1'b1, 13'h1C0, 16'h2222);
    chk_if.ready    = 1'b1;
    mem_req_ready_i = 1'b1;
    offer(mk(W_DO, 1'b1, 13'h180, 16'h0000));
    step();
    mem_req_ready_i = 1'b0;
    step();
    total_cnt++;
    if (fwd_if.ready !== 1'b0)
      $display("FAIL rst_wait_busy: got rdy=%b expected 0", fwd_if.ready);
    else pass_cnt++;
    rst_i = 1'b1;
    #1;
    total_cnt++;
    if ({chk_if.valid, mem_req_valid_o, fwd_update_valid, mem_fault_o} !== 4'b0000 || fwd_if.ready !== 1'b1)
      $display("FAIL rst_async: got outs=%b rdy=%b expected outs=0000 rdy=1",
               {chk_if.valid, mem_req_valid_o, fwd_update_valid, mem_fault_o}, fwd_if.ready);
    else pass_cnt++;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 64'h3333;
    step();
    mem_rsp_valid_i = 1'b0;
    rst_i = 1'b0;
    step();
    total_cnt++;
    if (fwd_update_valid !== 1'b0 || mem_fault_o !== 1'b0 || chk_if.valid !== 1'b0)
      $display("FAIL rst_no_pulse: got upd=%b f=%b v=%b expected 0 0 0",
               fwd_update_valid, mem_fault_o, chk_if.valid);
    else pass_cnt++;
    mem_req_ready_i = 1'b1;
    offer(mk(W_DO, 1'b1, 13'h1C0, 16'h0000));
    total_cnt++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 64'h1C0)
      $display("FAIL rst_after_req: got v=%b a=%h expected v=1 a=1c0", mem_req_valid_o, mem_req_addr_o);
    else pass_cnt++;
    step();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 64'h2222;
    step();
    mem_rsp_valid_i = 1'b0;
    total_cnt++;
    if (chk_if.valid !== 1'b1 || chk_if.data !== exp_t || fwd_update_valid !== 1'b1)
      $display("FAIL rst_after_out: got v=%b d=%h upd=%b expected v=1 d=%h upd=1",
               chk_if.valid, chk_if.data, fwd_update_valid, exp_t);
    else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_skip();
    test_passthrough();
    test_do_wait_states();
    test_do_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected summary");
    $fatal(1, "watchdog expired");
  end
endmodule
